// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcode constants and main-decoder control word type
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  // CBZ carries a register field in Op[2:0], so it is matched by mask/value.
  localparam logic [10:0] OP_CBZ_MASK = 11'b111_1111_1000;
  localparam logic [10:0] OP_CBZ_VAL  = 11'b101_1010_0000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   reg2loc;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    aluop_e aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};

endpackage

// File: rtl/main_decoder_comb.sv
// rtl/main_decoder_comb.sv - combinational LEGv8 opcode to control word decode
module main_decoder_comb
  import legv8_pkg::*;
(
  input  logic [10:0] Op,
  output ctrl_t       o_ctrl
);

  ctrl_t w_ctrl;
  logic  w_is_cbz;

  // Masking clears Op[2:0] before the compare, so unknown register bits still hit CBZ.
  assign w_is_cbz = ((Op & OP_CBZ_MASK) == OP_CBZ_VAL);

  always_comb begin
    w_ctrl = CTRL_NOP;
    case (Op) inside
      OP_LDUR: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.aluop    = ALUOP_ADD;
      end
      OP_STUR: begin
        w_ctrl.reg2loc  = 1'b1;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_ADD;
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.aluop    = ALUOP_RTYPE;
      end
      default: begin
        if (w_is_cbz) begin
          w_ctrl.reg2loc = 1'b1;
          w_ctrl.branch  = 1'b1;
          w_ctrl.aluop   = ALUOP_CBZ;
        end
      end
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - registered LEGv8 main control decoder
module main_decoder
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp
);

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;

  main_decoder_comb u_comb (
    .Op     (Op),
    .o_ctrl (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= CTRL_NOP;
    end else begin
      r_ctrl <= w_ctrl;
    end
  end

  assign Reg2Loc  = r_ctrl.reg2loc;
  assign ALUSrc   = r_ctrl.alusrc;
  assign MemtoReg = r_ctrl.memtoreg;
  assign RegWrite = r_ctrl.regwrite;
  assign MemRead  = r_ctrl.memread;
  assign MemWrite = r_ctrl.memwrite;
  assign Branch   = r_ctrl.branch;
  assign ALUOp    = r_ctrl.aluop;

endmodule

// File: tb/tb_main_decoder.sv
// tb/tb_main_decoder.sv - randomized self-checking bench for main_decoder
module tb_main_decoder;

  logic        clk;
  logic        reset;
  logic [10:0] Op;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;

  int n_tests = 0;
  int n_fail  = 0;

  main_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Reg2Loc  (Reg2Loc),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table: exact opcodes and their control words.
  logic [10:0] tbl_op [6];
  logic [8:0]  tbl_w  [6];

  initial begin
    tbl_op[0] = 11'b11111000010; tbl_w[0] = 9'b011110000;
    tbl_op[1] = 11'b11111000000; tbl_w[1] = 9'b110001000;
    tbl_op[2] = 11'b10001011000; tbl_w[2] = 9'b000100010;
    tbl_op[3] = 11'b11001011000; tbl_w[3] = 9'b000100010;
    tbl_op[4] = 11'b10001010000; tbl_w[4] = 9'b000100010;
    tbl_op[5] = 11'b10101010000; tbl_w[5] = 9'b000100010;
  end

  function automatic logic [8:0] ref_word(input logic [10:0] op);
    logic [8:0] w;
    w = 9'b000000000;
    for (int i = 0; i < 6; i++)
      if (op === tbl_op[i]) w = tbl_w[i];
    // CBZ: top eight bits select it, the low three are a don't-care register field.
    if ((op >> 3) === 8'b10110100) w = 9'b100000101;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp_w);
    n_tests++;
    if (obs !== exp_w) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp_w);
    end
  endtask

  function automatic logic [8:0] dut_word();
    return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp};
  endfunction

  // Apply inputs, take one rising edge, then check just after it.
  task automatic step(input string tag, input logic rst, input logic [10:0] op);
    logic [8:0] exp_w;
    reset = rst;
    Op    = op;
    exp_w = rst ? 9'b000000000 : ref_word(op);
    @(posedge clk);
    #1;
    check_eq(tag, dut_word(), exp_w);
  endtask

  logic [10:0] op_r;
  logic [10:0] cbz_z;
  logic [10:0] ldur_x;

  initial begin
    reset = 1'b1;
    Op    = 11'b11111000010;
    @(negedge clk);

    step("reset_1", 1'b1, 11'b11111000010);
    step("reset_2", 1'b1, 11'b11111000010);
    // Exact constants for the headline cases, independent of the model.
    reset = 1'b0; Op = 11'b11111000010; @(posedge clk); #1;
    check_eq("release_ldur", dut_word(), 9'b011110000);
    Op = 11'b11111000000; @(posedge clk); #1;
    check_eq("stur", dut_word(), 9'b110001000);

    step("cbz_000", 1'b0, 11'b10110100000);
    step("cbz_111", 1'b0, 11'b10110100111);
    cbz_z = 11'b10110100zzz;
    reset = 1'b0; Op = cbz_z; @(posedge clk); #1;
    check_eq("cbz_zzz", dut_word(), 9'b100000101);

    step("add", 1'b0, 11'b10001011000);
    step("sub", 1'b0, 11'b11001011000);
    step("and", 1'b0, 11'b10001010000);
    step("orr", 1'b0, 11'b10101010000);
    step("illegal_0", 1'b0, 11'b00000000000);
    step("illegal_1", 1'b0, 11'b11111111111);
    ldur_x = 11'bx1111000010;
    reset = 1'b0; Op = ldur_x; @(posedge clk); #1;
    check_eq("ldur_x", dut_word(), 9'b000000000);

    step("b2b_ldur", 1'b0, 11'b11111000010);
    step("b2b_stur", 1'b0, 11'b11111000000);
    step("b2b_rst",  1'b1, 11'b10110100000);
    step("b2b_cbz",  1'b0, 11'b10110100000);
    step("b2b_add",  1'b0, 11'b10001011000);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op_r = tbl_op[$urandom_range(0, 5)];
        1: op_r = {8'b10110100, 3'($urandom_range(0, 7))};
        2: op_r = tbl_op[$urandom_range(0, 5)] ^ (11'd1 << $urandom_range(0, 10));
        default: op_r = 11'($urandom);
      endcase
      step("random", ($urandom_range(0, 15) == 0), op_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
